// File: rtl/adpll_lock_monitor.sv
// Per-channel frequency monitor for the ADPLL ring outputs.
// Counts resynchronised rising edges per gate window and tracks lock against ref.
module adpll_lock_monitor #(
    parameter int NUM_CH       = 4,
    parameter int COUNT_WIDTH  = 12,
    parameter int GATE_CYCLES  = 25800,
    parameter int LOCK_TOL     = 2,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic                          fpga_clk_i,
    input  logic                          rst_pbn_i,
    input  logic                          enable_i,
    input  logic                          ref_i,
    input  logic [NUM_CH-1:0]             gen_i,
    output logic [COUNT_WIDTH-1:0]        ref_count_o,
    output logic [NUM_CH*COUNT_WIDTH-1:0] gen_count_o,
    output logic [NUM_CH-1:0]             locked_o,
    output logic                          all_locked_o,
    output logic                          valid_o
);

    localparam int NIN = NUM_CH + 1;
    localparam int CW  = COUNT_WIDTH;
    localparam int GW  = $clog2(GATE_CYCLES);
    localparam int SW  = $clog2(LOCK_WINDOWS + 1);

    localparam logic [CW-1:0] CMAX  = '1;
    localparam logic [GW-1:0] GLAST = GW'(GATE_CYCLES - 1);
    localparam logic [SW-1:0] SMAX  = SW'(LOCK_WINDOWS);
    localparam logic [CW:0]   TOL   = (CW + 1)'(LOCK_TOL);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_e;

    state_e state_q;

    logic [NIN-1:0] in_w;
    logic [NIN-1:0] s1_q;
    logic [NIN-1:0] s2_q;
    logic [NIN-1:0] dly_q;
    logic [NIN-1:0] edge_w;

    logic [GW-1:0] gate_q;
    logic          term_w;

    logic [CW-1:0] cnt_q [NIN];
    logic [CW-1:0] win_w [NIN];

    logic [SW-1:0] streak_q [NUM_CH];
    logic [SW-1:0] streak_d [NUM_CH];
    logic [NUM_CH-1:0] lock_d;

    logic [CW-1:0]        ref_cnt_q;
    logic [NUM_CH*CW-1:0] gen_cnt_q;
    logic [NUM_CH-1:0]    locked_q;
    logic                 all_q;
    logic                 valid_q;

    // Bit 0 is the reference, bit k+1 is node k.
    assign in_w   = {gen_i, ref_i};
    assign edge_w = s2_q & ~dly_q;
    assign term_w = (gate_q == GLAST);

    always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
        if (!rst_pbn_i) begin
            s1_q  <= '0;
            s2_q  <= '0;
            dly_q <= '0;
        end else begin
            s1_q  <= in_w;
            s2_q  <= s1_q;
            dly_q <= s2_q;
        end
    end

    // Window value includes the current cycle's edge and saturates.
    always_comb begin
        for (int i = 0; i < NIN; i++) begin
            win_w[i] = (cnt_q[i] == CMAX) ? CMAX : cnt_q[i] + CW'(edge_w[i]);
        end
    end

    always_comb begin
        logic [CW:0] a;
        logic [CW:0] b;
        logic [CW:0] d;
        logic        ok;
        a      = '0;
        b      = '0;
        d      = '0;
        ok     = 1'b0;
        lock_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            a  = {1'b0, win_w[k+1]};
            b  = {1'b0, win_w[0]};
            d  = (a >= b) ? a - b : b - a;
            ok = (d <= TOL) && (win_w[k+1] != CMAX) && (win_w[0] != CMAX);
            if (!ok) begin
                streak_d[k] = '0;
            end else if (streak_q[k] == SMAX) begin
                streak_d[k] = SMAX;
            end else begin
                streak_d[k] = streak_q[k] + SW'(1);
            end
            lock_d[k] = (streak_d[k] == SMAX);
        end
    end

    always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
        if (!rst_pbn_i) begin
            state_q   <= IDLE;
            gate_q    <= '0;
            ref_cnt_q <= '0;
            gen_cnt_q <= '0;
            locked_q  <= '0;
            all_q     <= 1'b0;
            valid_q   <= 1'b0;
            for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
            for (int k = 0; k < NUM_CH; k++) streak_q[k] <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    gate_q   <= '0;
                    locked_q <= '0;
                    all_q    <= 1'b0;
                    for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
                    for (int k = 0; k < NUM_CH; k++) streak_q[k] <= '0;
                    if (enable_i) state_q <= ARM;
                end
                default: begin
                    if (!enable_i) begin
                        state_q  <= IDLE;
                        gate_q   <= '0;
                        locked_q <= '0;
                        all_q    <= 1'b0;
                        for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
                        for (int k = 0; k < NUM_CH; k++) streak_q[k] <= '0;
                    end else if (term_w) begin
                        state_q <= RUN;
                        gate_q  <= '0;
                        for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
                        if (state_q == RUN) begin
                            valid_q   <= 1'b1;
                            ref_cnt_q <= win_w[0];
                            for (int k = 0; k < NUM_CH; k++) begin
                                gen_cnt_q[k*CW +: CW] <= win_w[k+1];
                                streak_q[k]           <= streak_d[k];
                            end
                            locked_q <= lock_d;
                            all_q    <= &lock_d;
                        end
                    end else begin
                        gate_q <= gate_q + GW'(1);
                        for (int i = 0; i < NIN; i++) cnt_q[i] <= win_w[i];
                    end
                end
            endcase
        end
    end

    assign ref_count_o  = ref_cnt_q;
    assign gen_count_o  = gen_cnt_q;
    assign locked_o     = locked_q;
    assign all_locked_o = all_q;
    assign valid_o      = valid_q;

endmodule

// File: tb/tb_adpll_lock_monitor.sv
// Bench for adpll_lock_monitor: vector table, directed corner sequences and
// randomized periodic inputs checked against a window-arithmetic model.
module tb_adpll_lock_monitor;

    localparam int NCH = 4;
    localparam int CW  = 12;
    localparam int G   = 100;
    localparam int TOL = 2;
    localparam int LW  = 4;
    localparam int NIN = NCH + 1;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic ref_s;
    logic [NCH-1:0] gen_s;

    logic [CW-1:0]     ref_cnt;
    logic [NCH*CW-1:0] gen_cnt;
    logic [NCH-1:0]    locked;
    logic              all_l;
    logic              valid;

    logic [2:0]       ref_cnt2;
    logic [NCH*3-1:0] gen_cnt2;
    logic [NCH-1:0]   locked2;
    logic             all_l2;
    logic             valid2;

    adpll_lock_monitor #(
        .NUM_CH(NCH), .COUNT_WIDTH(CW), .GATE_CYCLES(G),
        .LOCK_TOL(TOL), .LOCK_WINDOWS(LW)
    ) dut (
        .fpga_clk_i(clk), .rst_pbn_i(rst_n), .enable_i(en),
        .ref_i(ref_s), .gen_i(gen_s),
        .ref_count_o(ref_cnt), .gen_count_o(gen_cnt),
        .locked_o(locked), .all_locked_o(all_l), .valid_o(valid)
    );

    adpll_lock_monitor #(
        .NUM_CH(NCH), .COUNT_WIDTH(3), .GATE_CYCLES(G),
        .LOCK_TOL(TOL), .LOCK_WINDOWS(LW)
    ) dut_sat (
        .fpga_clk_i(clk), .rst_pbn_i(rst_n), .enable_i(en),
        .ref_i(ref_s), .gen_i(gen_s),
        .ref_count_o(ref_cnt2), .gen_count_o(gen_cnt2),
        .locked_o(locked2), .all_locked_o(all_l2), .valid_o(valid2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int                p;
        logic [CW-1:0]     rc;
        logic [NCH*CW-1:0] gc;
        logic [NCH-1:0]    lk;
        logic              al;
        logic [2:0]        rc2;
        logic [NCH*3-1:0]  gc2;
        logic [NCH-1:0]    lk2;
        logic              al2;
        logic              v2;
    } pub_t;

    typedef struct packed {
        logic [7:0]        pr;
        logic [7:0]        p0;
        logic [7:0]        p1;
        logic [7:0]        p2;
        logic [7:0]        p3;
        int                npub;
        int                eref;
        logic [NCH*CW-1:0] egen;
        logic [NCH-1:0]    dc;
        logic [NCH-1:0]    elk;
        logic              eall;
    } vec_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int e0 = 0;
    int per [NIN];
    int ph [NIN];
    logic [NIN-1:0] hist [4096];
    pub_t pubs [$];
    vec_t vt [4];

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic logic wave(int b, int n);
        if (per[b] == 0) return 1'b0;
        return ((n + ph[b]) % per[b]) < (per[b] / 2);
    endfunction

    // One clock: record inputs seen at the posedge, capture publishes at the
    // negedge, then drive the inputs for the next posedge.
    task automatic step();
        pub_t r;
        @(posedge clk);
        hist[cyc % 4096] = {gen_s, ref_s};
        cyc++;
        @(negedge clk);
        if (valid) begin
            r.p = cyc - 1;
            r.rc = ref_cnt; r.gc = gen_cnt; r.lk = locked; r.al = all_l;
            r.rc2 = ref_cnt2; r.gc2 = gen_cnt2; r.lk2 = locked2;
            r.al2 = all_l2; r.v2 = valid2;
            pubs.push_back(r);
        end
        ref_s = wave(0, cyc);
        for (int k = 0; k < NCH; k++) gen_s[k] = wave(k + 1, cyc);
    endtask

    task automatic do_reset();
        en = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        pubs.delete();
    endtask

    task automatic start();
        en = 1'b1;
        e0 = cyc;
    endtask

    task automatic wait_pubs(int n);
        int budget;
        budget = (n + 2) * G;
        while (pubs.size() < n && budget > 0) begin
            step();
            budget--;
        end
        chk("publish_count", pubs.size(), n);
    endtask

    task automatic set_all(int p);
        for (int b = 0; b < NIN; b++) begin
            per[b] = p;
            ph[b] = 0;
        end
    endtask

    // Expected results from the recorded waveforms: an input rise seen at
    // posedge n is counted at posedge n+2; windows tile from e0+1.
    task automatic model_check(string tag);
        int streak [NCH];
        int cnt [NIN];
        int p, d, ok, elk, eall;
        for (int k = 0; k < NCH; k++) streak[k] = 0;
        for (int i = 0; i < pubs.size(); i++) begin
            p = pubs[i].p;
            chk({tag, "_pub_cycle"}, p - e0, (i + 2) * G);
            for (int b = 0; b < NIN; b++) begin
                cnt[b] = 0;
                for (int m = p - G + 1; m <= p; m++) begin
                    if (hist[(m - 2) % 4096][b] && !hist[(m - 3) % 4096][b]
                        && cnt[b] < SAT)
                        cnt[b]++;
                end
            end
            chk({tag, "_ref_count"}, int'(pubs[i].rc), cnt[0]);
            elk = 0;
            for (int k = 0; k < NCH; k++) begin
                chk({tag, "_gen_count"}, int'(pubs[i].gc[k*CW +: CW]), cnt[k+1]);
                d = cnt[k+1] - cnt[0];
                if (d < 0) d = -d;
                ok = (d <= TOL) && (cnt[k+1] != SAT) && (cnt[0] != SAT);
                streak[k] = ok ? ((streak[k] < LW) ? streak[k] + 1 : LW) : 0;
                if (streak[k] == LW) elk |= (1 << k);
            end
            eall = (elk == (1 << NCH) - 1);
            chk({tag, "_locked"}, int'(pubs[i].lk), elk);
            chk({tag, "_all_locked"}, int'(pubs[i].al), eall);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_ref_count"}, int'(ref_cnt), 0);
        chk({tag, "_gen_count"}, int'(gen_cnt != '0), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_all_locked"}, int'(all_l), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_sat_ref"}, int'(ref_cnt2), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        pub_t r;
        en = 1'b0;
        rst_n = 1'b0;
        ref_s = 1'b0;
        gen_s = '0;
        set_all(10);

        vt[0] = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 3, 10,
                  {4{12'd10}}, 4'b0000, 4'b0000, 1'b0};
        vt[1] = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 4, 10,
                  {4{12'd10}}, 4'b0000, 4'b1111, 1'b1};
        vt[2] = '{8'd10, 8'd10, 8'd7, 8'd10, 8'd10, 6, 10,
                  {4{12'd10}}, 4'b0010, 4'b1101, 1'b0};
        vt[3] = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 5, 25,
                  {4{12'd25}}, 4'b0000, 4'b1111, 1'b1};

        do_reset();
        chk_zero("reset");

        for (int v = 0; v < 4; v++) begin
            do_reset();
            per[0] = vt[v].pr; per[1] = vt[v].p0; per[2] = vt[v].p1;
            per[3] = vt[v].p2; per[4] = vt[v].p3;
            for (int b = 0; b < NIN; b++) ph[b] = 0;
            start();
            wait_pubs(vt[v].npub);
            if (pubs.size() == vt[v].npub) begin
                r = pubs[vt[v].npub - 1];
                chk("tbl_first_valid", pubs[0].p - e0 + 1, 2 * G + 1);
                chk("tbl_ref", int'(r.rc), vt[v].eref);
                for (int k = 0; k < NCH; k++) begin
                    if (!vt[v].dc[k])
                        chk("tbl_gen", int'(r.gc[k*CW +: CW]),
                            int'(vt[v].egen[k*CW +: CW]));
                end
                chk("tbl_locked", int'(r.lk), int'(vt[v].elk));
                chk("tbl_all", int'(r.al), int'(vt[v].eall));
                chk("tbl_prev_locked", int'(pubs[vt[v].npub - 2].lk),
                    (vt[v].npub - 1 >= LW) ? int'(vt[v].elk) : 0);
                chk("sat_valid", int'(r.v2), 1);
                chk("sat_ref", int'(r.rc2), 7);
                chk("sat_gen", int'(r.gc2), 12'o7777);
                chk("sat_locked", int'(r.lk2), 0);
                chk("sat_all", int'(r.al2), 0);
                model_check("tbl_model");
            end
        end

        // Loss of lock on ch2
        do_reset();
        set_all(10);
        start();
        wait_pubs(4);
        per[3] = 0;
        wait_pubs(5);
        if (pubs.size() == 5) begin
            chk("lol_locked", int'(pubs[4].lk), 4'b1011);
            chk("lol_all", int'(pubs[4].al), 0);
        end
        wait_pubs(6);
        if (pubs.size() == 6) begin
            chk("lol_gen2", int'(pubs[5].gc[2*CW +: CW]), 0);
            chk("lol_locked2", int'(pubs[5].lk), 4'b1011);
        end

        // Enable dropped mid-window in RUN
        do_reset();
        set_all(10);
        start();
        wait_pubs(4);
        repeat (50) step();
        en = 1'b0;
        step();
        chk("drop_locked", int'(locked), 0);
        chk("drop_all", int'(all_l), 0);
        chk("drop_ref_hold", int'(ref_cnt), 10);
        chk("drop_gen_hold", int'(gen_cnt[3*CW +: CW]), 10);
        repeat (150) step();
        chk("drop_no_valid", pubs.size(), 4);
        start();
        wait_pubs(5);
        if (pubs.size() == 5) begin
            chk("reen_first_valid", pubs[4].p - e0 + 1, 2 * G + 1);
            chk("reen_locked", int'(pubs[4].lk), 0);
        end

        // Asynchronous reset between clock edges
        do_reset();
        set_all(10);
        start();
        wait_pubs(4);
        repeat (30) step();
        chk("pre_rst_locked", int'(locked), 4'b1111);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        step();
        rst_n = 1'b1;
        en = 1'b0;
        step();
        chk_zero("post_rst");
        pubs.delete();
        start();
        wait_pubs(4);
        model_check("after_rst");

        // Randomized periods/phases; trial 0 is the ch1 period-8 boundary case
        for (int t = 0; t < 6; t++) begin
            do_reset();
            per[0] = 10;
            ph[0] = $urandom_range(9, 0);
            for (int b = 1; b < NIN; b++) begin
                per[b] = $urandom_range(12, 8);
                ph[b] = $urandom_range(per[b] - 1, 0);
            end
            if (t == 0) begin
                per[1] = 10; per[2] = 8; per[3] = 10; per[4] = 10;
            end
            start();
            wait_pubs(7);
            model_check("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adpll_lock_monitor.md
# adpll_lock_monitor

Measures the frequency of up to four ADPLL network outputs against the loop reference and flags per-node lock. It sits directly downstream of the 2x2 ADPLL ring network on the `fpga_clk_i` domain (258 MHz). It consumes each node's `gen_div8` output and the registered external reference. Its counts and lock flags feed the board LEDs, the 7-segment display mux and the PMOD debug header.

## Interface
Parameters:
- `NUM_CH`, 4: number of monitored ADPLL outputs.
- `COUNT_WIDTH`, 12: width of each edge counter; counters saturate at all-ones.
- `GATE_CYCLES`, 25800: length of one measurement window in `fpga_clk_i` cycles (100 us at 258 MHz). Legal range is 2 to 2^20-1.
- `LOCK_TOL`, 2: maximum |gen − ref| edge-count difference that counts as "in tolerance".
- `LOCK_WINDOWS`, 4: number of consecutive in-tolerance windows needed to assert lock.

Ports:
- `fpga_clk_i`, in, 1: sampling clock.
- `rst_pbn_i`, in, 1: reset, asynchronous, active-low. This is the one clock and this is the reset; both are fixed.
- `enable_i`, in, 1: measurement enable, synchronous.
- `ref_i`, in, 1: reference clock. It is asynchronous to `fpga_clk_i` and is resynchronised internally.
- `gen_i`, in, `NUM_CH`: ADPLL divided outputs. Bit k is node k. Asynchronous; resynchronised internally.
- `ref_count_o`, out, `COUNT_WIDTH`: reference rising edges counted in the last completed window.
- `gen_count_o`, out, `NUM_CH*COUNT_WIDTH`: per-channel rising edges in the last completed window. Channel k occupies bits `[k*COUNT_WIDTH +: COUNT_WIDTH]`.
- `locked_o`, out, `NUM_CH`: per-channel lock flag.
- `all_locked_o`, out, 1: AND of `locked_o`.
- `valid_o`, out, 1: one-cycle pulse when new counts and lock flags are published.

## Operation
- **Synchronisers.** Each of `ref_i` and `gen_i[k]` passes through a 2-flop synchroniser and then a delay flop. A rising edge is `sync & ~dly`. Synchroniser flops reset to 0.
- **Counters.** There is one gate counter, 0..`GATE_CYCLES`-1. There is one edge counter per input (`NUM_CH`+1 of them). Edge counters increment on each detected edge and saturate at 2^`COUNT_WIDTH`-1.
- **FSM states:**
  - IDLE: entered on reset, and whenever `enable_i`=0. All counters and lock streaks are held at 0. `locked_o` is cleared. Published counts hold their last value.
  - ARM: entered from IDLE when `enable_i`=1. Runs one full window. Results are discarded (no publish, no lock update). At the terminal cycle the FSM moves to RUN.
  - RUN: runs windows back-to-back. At each terminal gate cycle it publishes and updates lock.
- **Terminal gate cycle (gate counter = `GATE_CYCLES`-1):**
  - The window value is the edge counter plus that cycle's edge, saturated. An edge on the terminal cycle belongs to the closing window.
  - In RUN, the window value is written to the output register.
  - Edge counters and the gate counter reload to 0. There is no dead cycle between windows.
- **Lock update (RUN only), per channel k:**
  - diff = |gen_k − ref|, computed at `COUNT_WIDTH`+1 bits with no wrap.
  - If diff ≤ `LOCK_TOL`, streak_k increments, saturating at `LOCK_WINDOWS`. Otherwise streak_k clears to 0.
  - `locked_o[k]` = (new streak_k == `LOCK_WINDOWS`).
  - A saturated count on either side forces that channel out of tolerance.
- **Enable deasserted mid-window.** The FSM goes to IDLE on the next cycle. The partial window is discarded. No `valid_o` is produced. On re-enable the FSM restarts from ARM.
- **Reset mid-window.** All state clears immediately, asynchronously.

## Timing
- Reset value of every output is 0: `ref_count_o`, `gen_count_o`, `locked_o`, `all_locked_o`, `valid_o`.
- Input edge to edge-detect pulse: 3 `fpga_clk_i` cycles.
- `valid_o` is high for exactly one cycle, the cycle after the terminal gate cycle. On that same cycle `ref_count_o`, `gen_count_o`, `locked_o` and `all_locked_o` take their new values. Between pulses they are stable.
- The first `valid_o` after enable arrives 2·`GATE_CYCLES`+1 cycles after the first cycle with `enable_i`=1 sampled high in IDLE.
- After that, `valid_o` has period exactly `GATE_CYCLES`.
- Lock asserts at the earliest on the `LOCK_WINDOWS`-th RUN publish. It deasserts on the first out-of-tolerance publish.

## Test plan
Bench parameters: `GATE_CYCLES`=100, `LOCK_TOL`=2, `LOCK_WINDOWS`=4.
- **Matched frequencies.** `ref_i` and all `gen_i` period 10 cycles, enable at t0. Required: first `valid_o` at t0+201, ref_count=10 and every gen_count=10. `locked_o`=4'b1111 and `all_locked_o`=1 on the 4th pulse, not earlier.
- **Tolerance boundary.** Ch1 period 8 (12–13 edges), the others period 10. Required: ch1 diff ≥2 is accepted only while diff ≤2, so ch1 locks only if every window count is ≤12. With ch1 period 7 (14–15 edges), `locked_o[1]` stays 0 and `all_locked_o`=0.
- **Loss of lock.** Reach lock on all channels, then stop ch2 (held low). Required: on the next publish gen_count ch2=0, `locked_o[2]`=0 and `all_locked_o`=0. The other channels stay locked.
- **Saturation.** Set `COUNT_WIDTH`=3 and drive ref at period 4 (25 edges). Required: ref_count=7, no wrap, and all channels are out of tolerance.
- **Enable dropped mid-window.** Drop `enable_i` at gate count 50 in RUN. Required: no `valid_o`, `locked_o`=0 on the next cycle, and counts hold. On re-enable, the next `valid_o` arrives 201 cycles later.
- **Async reset mid-window.** Assert `rst_pbn_i` low between clock edges. Required: all outputs are 0 before the next clock edge, and operation resumes from IDLE after release.
